// File: rtl/contador_universal_if.sv
// Control/status bundle for contador_universal.
// CONTADOR_UNIVERSAL_OVF_EN adds the sticky overflow flag and its clear strobe.
interface contador_universal_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up_down;
  logic             modo;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cuenta;
  logic             tc;
`ifdef CONTADOR_UNIVERSAL_OVF_EN
  logic             ovf_clr;
  logic             ovf;

  modport master (
    output en, up_down, modo, load, load_val, ovf_clr,
    input  cuenta, tc, ovf
  );
  modport slave (
    input  en, up_down, modo, load, load_val, ovf_clr,
    output cuenta, tc, ovf
  );
`else
  modport master (
    output en, up_down, modo, load, load_val,
    input  cuenta, tc
  );
  modport slave (
    input  en, up_down, modo, load, load_val,
    output cuenta, tc
  );
`endif
endinterface

// File: rtl/contador_universal.sv
// Up/down modulo counter with wrap or saturate at the range ends and a clamped synchronous load.
// Define CONTADOR_UNIVERSAL_OVF_EN to add a sticky overflow flag (ovf) with clear (ovf_clr).
module contador_universal #(
  parameter int unsigned     WIDTH  = 8,
  parameter longint unsigned MODULO = 256
) (
  input logic                 clk,
  input logic                 rst,
  contador_universal_if.slave bus
);

  // MODULO may be 2^WIDTH, so it only fits the wider type; MODULO-1 always fits WIDTH bits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 64'd1);

  logic [WIDTH-1:0] cuenta_q, cuenta_d;
  logic             tc_q, tc_d;
  logic             at_end;

  always_comb begin
    cuenta_d = cuenta_q;
    tc_d     = 1'b0;
    at_end   = bus.up_down ? (cuenta_q == MaxVal) : (cuenta_q == '0);
    if (bus.load) begin
      cuenta_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
    end else if (bus.en) begin
      if (at_end) begin
        tc_d = 1'b1;
        if (!bus.modo) begin
          cuenta_d = bus.up_down ? '0 : MaxVal;
        end
      end else if (bus.up_down) begin
        cuenta_d = cuenta_q + WIDTH'(1);
      end else begin
        cuenta_d = cuenta_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cuenta_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.cuenta = cuenta_q;
  assign bus.tc     = tc_q;

`ifdef CONTADOR_UNIVERSAL_OVF_EN
  logic ovf_q, ovf_d;

  // A new terminal event wins over a coincident clear.
  always_comb begin
    ovf_d = tc_d | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_contador_universal.sv
// Self-checking bench for contador_universal (WIDTH=4, MODULO=10): cycle model plus directed vectors.
module tb_contador_universal;

  localparam int unsigned W   = 4;
  localparam int          MOD = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  contador_universal_if #(.WIDTH(W)) bus ();

  contador_universal #(
    .WIDTH (W),
    .MODULO(MOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular / clamped arithmetic on integers.
  int m_cuenta = 0;
  bit m_tc     = 1'b0;
  bit m_ovf    = 1'b0;
  bit clr_now;

`ifdef CONTADOR_UNIVERSAL_OVF_EN
  assign clr_now = bus.ovf_clr;
`else
  assign clr_now = 1'b0;
`endif

  function automatic int next_count(input int c, input bit up, input bit sat);
    if (sat) return up ? ((c + 1 > MOD - 1) ? MOD - 1 : c + 1) : ((c == 0) ? 0 : c - 1);
    return up ? (c + 1) % MOD : (c + MOD - 1) % MOD;
  endfunction

  function automatic bit at_terminal(input int c, input bit up);
    return up ? (c == MOD - 1) : (c == 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cuenta <= 0;
      m_tc     <= 1'b0;
      m_ovf    <= 1'b0;
    end else if (bus.load) begin
      m_cuenta <= (int'(bus.load_val) >= MOD) ? MOD - 1 : int'(bus.load_val);
      m_tc     <= 1'b0;
      m_ovf    <= m_ovf && !clr_now;
    end else if (bus.en) begin
      m_cuenta <= next_count(m_cuenta, bus.up_down, bus.modo);
      m_tc     <= at_terminal(m_cuenta, bus.up_down);
      m_ovf    <= at_terminal(m_cuenta, bus.up_down) || (m_ovf && !clr_now);
    end else begin
      m_tc     <= 1'b0;
      m_ovf    <= m_ovf && !clr_now;
    end
  end

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    check("model cuenta", bus.cuenta, m_cuenta);
    check("model tc", bus.tc, m_tc);
`ifdef CONTADOR_UNIVERSAL_OVF_EN
    check("model ovf", bus.ovf, m_ovf);
`endif
  end

  // One rising edge, then literal checks on the following falling edge (negative = skip).
  task automatic step(input string tag, input int exp_c, input int exp_tc);
    @(posedge clk);
    @(negedge clk);
    if (exp_c >= 0) check({tag, " cuenta"}, bus.cuenta, exp_c);
    if (exp_tc >= 0) check({tag, " tc"}, bus.tc, exp_tc);
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = W'(v);
    step("load", -1, 0);
    bus.load     = 1'b0;
  endtask

  int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    bus.en       = 1'b0;
    bus.up_down  = 1'b1;
    bus.modo     = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
`ifdef CONTADOR_UNIVERSAL_OVF_EN
    bus.ovf_clr  = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset cuenta", bus.cuenta, 0);
    check("reset tc", bus.tc, 0);
    rst = 1'b1;

    // Up count with wrap
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step("up wrap", up_seq[i], (i == 9) ? 1 : 0);
    end

    // Down wrap from 0
    do_load(0);
    bus.up_down = 1'b0;
    step("down wrap", 9, 1);
    bus.en = 1'b0;
    step("hold", 9, 0);

    // Saturate high for 3 edges
    bus.en      = 1'b1;
    bus.modo    = 1'b1;
    bus.up_down = 1'b1;
    for (int i = 0; i < 3; i++) step("sat up", 9, 1);

    // Saturate low
    do_load(0);
    bus.up_down = 1'b0;
    for (int i = 0; i < 2; i++) step("sat down", 0, 1);

    // Load clamp, load priority over en
    bus.up_down  = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'd13;
    step("load 13", 9, 0);
    bus.load_val = 4'd4;
    step("load 4", 4, 0);
    bus.load_val = 4'd10;
    step("load 10", 9, 0);
    bus.load_val = 4'd15;
    step("load 15", 9, 0);
    bus.load     = 1'b0;

    // Direction change takes effect on the same edge
    bus.modo = 1'b0;
    do_load(4);
    step("dir up", 5, 0);
    bus.up_down = 1'b0;
    step("dir down", 4, 0);
    bus.up_down = 1'b1;

    // Async reset pulse between edges at cuenta=7
    do_load(7);
    #1 rst = 1'b0;
    #1;
    check("async rst cuenta", bus.cuenta, 0);
    check("async rst tc", bus.tc, 0);
    #1 rst = 1'b1;
    step("resume", 1, 0);
    step("resume", 2, 0);

    // Async reset clears a pending tc
    do_load(9);
    step("wrap before rst", 0, 1);
    #1 rst = 1'b0;
    #1;
    check("async rst tc after wrap", bus.tc, 0);
    #1 rst = 1'b1;

    // Inputs ignored while reset is held across an edge
    rst          = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 4'd5;
    step("load in rst", 0, 0);
    bus.load     = 1'b0;
    rst          = 1'b1;
    step("post rst", 1, 0);

`ifdef CONTADOR_UNIVERSAL_OVF_EN
    do_load(8);
    step("ovf pre", 9, 0);
    check("ovf pre", bus.ovf, 0);
    step("ovf wrap", 0, 1);
    check("ovf set", bus.ovf, 1);
    for (int i = 1; i <= 5; i++) begin
      step("ovf sticky", i, 0);
      check("ovf sticky", bus.ovf, 1);
    end
    for (int i = 6; i <= 9; i++) step("ovf climb", i, 0);
    bus.ovf_clr = 1'b1;
    step("ovf clr+wrap", 0, 1);
    check("ovf clr+wrap", bus.ovf, 1);
    bus.en = 1'b0;
    step("ovf clr", 0, 0);
    check("ovf clr", bus.ovf, 0);
    bus.ovf_clr = 1'b0;
`endif

    bus.en = 1'b0;
    step("final hold", -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
